// File: rtl/ngram_temporal_encoder_pkg.sv
// Shared defaults and state encodings for the N-gram temporal encoder.
// rev 1.0
`default_nettype none

package ngram_temporal_encoder_pkg;

  localparam int DEFAULT_HV_DIMENSION = 2000;
  localparam int DEFAULT_MAX_NGRAM    = 5;

  localparam logic ST_WARMUP = 1'b0;
  localparam logic ST_STREAM = 1'b1;

  typedef enum logic {
    WARMUP = ST_WARMUP,
    STREAM = ST_STREAM
  } enc_state_e;

endpackage

`default_nettype wire

// File: rtl/hv_history_shift.sv
// History chain H[1..DEPTH]: every shift rotates the new sample into H[1] and ripples older entries.
// rev 1.0
`default_nettype none

module hv_history_shift #(
  parameter int HV_DIMENSION = 2000,
  parameter int DEPTH        = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic                                  shift,
  input  logic [0:HV_DIMENSION-1]               sample,
  output logic [DEPTH-1:0][0:HV_DIMENSION-1]    history
);

  // Bit 0 is the MSB, so the LSB wraps around to the front.
  function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
    return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history <= '0;
    end else if (clear) begin
      history <= '0;
    end else if (shift) begin
      history[0] <= rho(sample);
      for (int k = 1; k < DEPTH; k++) begin
        history[k] <= rho(history[k-1]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ngram_temporal_encoder.sv
// N-gram temporal encoder: binds the input with rotated history and emits one result per streaming accept.
// rev 1.0
`default_nettype none

module ngram_temporal_encoder
  import ngram_temporal_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = DEFAULT_HV_DIMENSION,
  parameter int MAX_NGRAM    = DEFAULT_MAX_NGRAM,
  parameter int NGRAM_W      = $clog2(MAX_NGRAM + 1)
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    Clear_SI,
  input  logic [NGRAM_W-1:0]      NGramSize_SI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
  output logic                    Primed_SO
);

  localparam int HIST_DEPTH = (MAX_NGRAM > 1) ? MAX_NGRAM - 1 : 1;
  localparam logic [NGRAM_W-1:0] N_ONE = NGRAM_W'(1);
  localparam logic [NGRAM_W-1:0] N_MAX = NGRAM_W'(MAX_NGRAM);

  enc_state_e                              state, state_next;
  logic [NGRAM_W-1:0]                      n_latched, n_req, n_eff;
  logic [NGRAM_W-1:0]                      fill, fill_next;
  logic                                    at_fill0, accept, stream_accept;
  logic [HIST_DEPTH-1:0][0:HV_DIMENSION-1] history;
  logic [0:HV_DIMENSION-1]                 bound;
  logic [0:HV_DIMENSION-1]                 out_data;
  logic                                    out_valid;

  always_comb begin
    if (NGramSize_SI == '0) begin
      n_req = N_ONE;
    end else if (NGramSize_SI > N_MAX) begin
      n_req = N_MAX;
    end else begin
      n_req = NGramSize_SI;
    end
  end

  // While warming up with an empty history the size port is live, so that cycle binds with it directly.
  assign at_fill0      = (state == WARMUP) && (fill == '0);
  assign n_eff         = at_fill0 ? n_req : n_latched;
  assign ReadyOut_SO   = Reset_RBI & ~Clear_SI & (~out_valid | ReadyIn_SI);
  assign accept        = ValidIn_SI & ReadyOut_SO;
  assign stream_accept = accept & ((state == STREAM) | (at_fill0 & (n_req == N_ONE)));

  hv_history_shift #(
    .HV_DIMENSION (HV_DIMENSION),
    .DEPTH        (HIST_DEPTH)
  ) u_history (
    .clk     (Clk_CI),
    .rst_n   (Reset_RBI),
    .clear   (Clear_SI),
    .shift   (accept),
    .sample  (HypervectorIn_DI),
    .history (history)
  );

  always_comb begin
    bound = HypervectorIn_DI;
    for (int k = 1; k <= HIST_DEPTH; k++) begin
      if (k < int'(n_eff)) begin
        bound = bound ^ history[k-1];
      end
    end
  end

  always_comb begin
    state_next = state;
    fill_next  = fill;
    if (Clear_SI) begin
      state_next = (n_req == N_ONE) ? STREAM : WARMUP;
      fill_next  = '0;
    end else if (state == WARMUP) begin
      if (at_fill0 && (n_req == N_ONE)) begin
        state_next = STREAM;
      end else if (accept) begin
        if ((fill + N_ONE) == (n_eff - N_ONE)) begin
          state_next = STREAM;
        end
        fill_next = fill + N_ONE;
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state     <= WARMUP;
      fill      <= '0;
      n_latched <= N_ONE;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      if (Clear_SI || at_fill0) begin
        n_latched <= n_req;
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (Clear_SI) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (stream_accept) begin
      out_valid <= 1'b1;
      out_data  <= bound;
    end else if (ReadyIn_SI) begin
      out_valid <= 1'b0;
    end
  end

  assign ValidOut_SO       = out_valid;
  assign HypervectorOut_DO = out_data;
  assign Primed_SO         = (state == STREAM);

endmodule

`default_nettype wire

// File: tb/tb_ngram_temporal_encoder.sv
// Scoreboard bench for ngram_temporal_encoder at HV_DIMENSION=8, MAX_NGRAM=4.
// rev 1.0
`default_nettype none

module tb_ngram_temporal_encoder;

  localparam int HV   = 8;
  localparam int MAXN = 4;
  localparam int NW   = $clog2(MAXN + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [NW-1:0] size;
  logic          vin;
  logic          rdy_out;
  logic [0:HV-1] din;
  logic          vout;
  logic          rdy_in;
  logic [0:HV-1] dout;
  logic          primed;

  always #5 clk = ~clk;

  ngram_temporal_encoder #(
    .HV_DIMENSION (HV),
    .MAX_NGRAM    (MAXN)
  ) dut (
    .Clk_CI            (clk),
    .Reset_RBI         (rst_n),
    .Clear_SI          (clear),
    .NGramSize_SI      (size),
    .ValidIn_SI        (vin),
    .ReadyOut_SO       (rdy_out),
    .HypervectorIn_DI  (din),
    .ValidOut_SO       (vout),
    .ReadyIn_SI        (rdy_in),
    .HypervectorOut_DO (dout),
    .Primed_SO         (primed)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  logic [7:0] m_hist[1:MAXN-1];
  int         m_n, m_c;
  bit         m_stream, m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampn(input int s);
    if (s == 0) return 1;
    if (s > MAXN) return MAXN;
    return s;
  endfunction

  // Numeric LSB is bit HV-1 in the [0:HV-1] view, so it wraps to the numeric MSB.
  function automatic logic [7:0] rho(input logic [7:0] x);
    return {x[0], x[7:1]};
  endfunction

  task automatic model_reset();
    for (int k = 1; k < MAXN; k++) m_hist[k] = '0;
    m_c      = 0;
    m_n      = 1;
    m_stream = 1'b0;
    m_valid  = 1'b0;
    sb.delete();
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input bit r, input bit c, input int s);
    logic [7:0] b;
    int         nn, neff;
    bit         warm0, acc, rdy_exp;
    vin    = v;
    din    = d;
    rdy_in = r;
    clear  = c;
    size   = NW'(s);
    @(negedge clk);
    rdy_exp = !c && (!m_valid || r);
    check("ready_out", rdy_out, rdy_exp);
    check("primed", primed, m_stream);
    check("valid_out", vout, m_valid);
    if (m_valid && sb.size() > 0) begin
      check("hv_out", dout, sb[0]);
      if (r) void'(sb.pop_front());
    end
    warm0 = !m_stream && (m_c == 0);
    nn    = clampn(s);
    neff  = warm0 ? nn : m_n;
    acc   = v && rdy_exp;
    if (c) begin
      for (int k = 1; k < MAXN; k++) m_hist[k] = '0;
      m_c      = 0;
      m_valid  = 1'b0;
      m_n      = nn;
      m_stream = (nn == 1);
      sb.delete();
    end else begin
      if (acc && (m_stream || (warm0 && nn == 1))) begin
        b = d;
        for (int k = 1; k < MAXN; k++) if (k < neff) b = b ^ m_hist[k];
        sb.push_back(b);
        m_valid = 1'b1;
      end else if (r) begin
        m_valid = 1'b0;
      end
      if (warm0) m_n = nn;
      if (!m_stream) begin
        if (warm0 && nn == 1) begin
          m_stream = 1'b1;
        end else if (acc) begin
          m_c++;
          if (m_c == neff - 1) m_stream = 1'b1;
        end
      end
      if (acc) begin
        for (int k = MAXN - 1; k > 1; k--) m_hist[k] = rho(m_hist[k-1]);
        m_hist[1] = rho(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    vin    = 1'b0;
    din    = '0;
    rdy_in = 1'b1;
    clear  = 1'b0;
    size   = NW'(3);
    model_reset();
    #12;
    check("rst_valid", vout, 0);
    check("rst_hv", dout, 0);
    check("rst_ready", rdy_out, 0);
    check("rst_primed", primed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // n=3 basic binding
    tick(1, 8'h01, 1, 0, 3); check("n3_v1", vout, 0);
    tick(1, 8'h02, 1, 0, 3); check("n3_v2", vout, 0);
    tick(1, 8'h04, 1, 0, 3);
    check("n3_valid", vout, 1);
    check("n3_hv", dout, 8'h45);
    check("n3_primed", primed, 1);
    for (int i = 0; i < 4; i++) tick(1, 8'($urandom), 1, 0, 3);

    // size change ignored while streaming, then latched by clear
    for (int i = 0; i < 4; i++) tick(1, 8'($urandom), 1, 0, 2);
    tick(0, 8'h00, 1, 1, 2);
    tick(1, 8'hA5, 1, 0, 2);
    check("n2_primed", primed, 1);
    check("n2_nooutput", vout, 0);
    tick(1, 8'h3C, 1, 0, 2);
    for (int i = 0; i < 3; i++) tick(1, 8'h77, 0, 0, 2);
    check("stall_ready", rdy_out, 0);
    tick(1, 8'hC3, 1, 0, 2);
    tick(0, 8'h00, 1, 0, 2);

    // clear in STREAM with n=3
    tick(1, 8'h10, 1, 0, 3);
    tick(0, 8'h00, 1, 1, 3);
    check("clr_valid", vout, 0);
    check("clr_primed", primed, 0);
    tick(1, 8'h21, 1, 0, 3); check("clr_w1", vout, 0);
    tick(1, 8'h42, 1, 0, 3); check("clr_w2", vout, 0);
    tick(1, 8'h84, 1, 0, 3); check("clr_out", vout, 1);

    // size 0 clamps to 1: pass-through back-to-back
    tick(0, 8'h00, 1, 1, 0);
    check("n1_primed", primed, 1);
    tick(1, 8'h11, 1, 0, 5); check("n1_hv11", dout, 8'h11);
    tick(1, 8'h22, 1, 0, 5); check("n1_hv22", dout, 8'h22);
    tick(1, 8'h33, 1, 0, 5); check("n1_hv33", dout, 8'h33);
    tick(0, 8'h00, 1, 0, 5);

    // size 7 clamps to 4
    tick(0, 8'h00, 1, 1, 7);
    for (int i = 0; i < 3; i++) tick(1, 8'(8'h01 << i), 1, 0, 7);
    check("n4_primed", primed, 1);
    check("n4_nooutput", vout, 0);
    tick(1, 8'h08, 1, 0, 7);
    check("n4_valid", vout, 1);

    // randomized traffic with occasional clears and a live size port
    for (int i = 0; i < 200; i++) begin
      tick(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
           ($urandom % 25) == 0, int'($urandom % 8));
    end

    // asynchronous reset with a held output
    tick(0, 8'h00, 1, 1, 2);
    tick(1, 8'h5A, 1, 0, 2);
    tick(1, 8'h96, 0, 0, 2);
    check("pre_rst_valid", vout, 1);
    #2;
    rst_n = 1'b0;
    vin   = 1'b0;
    #1;
    check("arst_valid", vout, 0);
    check("arst_hv", dout, 0);
    check("arst_ready", rdy_out, 0);
    check("arst_primed", primed, 0);
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    rdy_in = 1'b1;
    @(posedge clk);
    #1;
    tick(1, 8'hF0, 1, 0, 3); check("post_rst_w1", vout, 0);
    tick(1, 8'h0F, 1, 0, 3); check("post_rst_w2", vout, 0);
    tick(1, 8'hFF, 1, 0, 3); check("post_rst_out", vout, 1);
    tick(0, 8'h00, 1, 0, 3);
    tick(0, 8'h00, 1, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
